// File: rtl/data_mem_bank_pkg.sv
// Shared types for the MEM-stage data memory bank.
package data_mem_pkg;

  // ST_INIT sweeps zeros through the array; ST_READY serves requests.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_bank_if.sv
// Request/response bus between the MEM stage and the data memory bank.
interface data_mem_bank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_bank_rsp_pipe.sv
// Fixed-latency response shift register; reset empties every stage.
module mem_rsp_pipe #(
  parameter int  LATENCY = 1,
  parameter type rsp_t   = logic
) (
  input  logic i_clock,
  input  logic i_flush,
  input  rsp_t i_rsp,
  output rsp_t o_rsp
);
  rsp_t r_stage [LATENCY];

  // Stage 0 captures the response at the accept edge, later stages just shift.
  always_ff @(posedge i_clock) begin
    if (i_flush) begin
      for (int k = 0; k < LATENCY; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_rsp;
      for (int k = 1; k < LATENCY; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_rsp = r_stage[LATENCY-1];
endmodule

// File: rtl/data_mem_bank.sv
// Byte-maskable data memory with power-up clear, range check and
// fixed-latency in-order responses.
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  data_mem_bank_if.slave   io_bus
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;
  } rsp_t;

  state_e                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready, w_clear, w_accept, w_in_range, w_mem_we;
  logic [CNT_WIDTH-1:0]  w_idx, w_widx;
  logic [BE_WIDTH-1:0]   w_wbe;
  logic [DATA_WIDTH-1:0] w_wdata;
  rsp_t                  w_rsp_in, w_rsp_out;

  // Full-width compare so out-of-range addresses never alias onto low words.
  assign w_in_range = ({1'b0, io_bus.req_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign w_idx      = io_bus.req_addr[CNT_WIDTH-1:0];

  // State and clear counter register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: clear one word per cycle, then serve requests forever.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clear   = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_WIDTH'(DEPTH - 1)) w_state_nxt = ST_READY;
      end
      ST_READY: w_ready = 1'b1;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  assign io_bus.req_ready = w_ready;
  // A handshake coinciding with reset is dropped; the flush would lose its response anyway.
  assign w_accept = w_ready & io_bus.req_valid & ~i_reset;

  // The clear sweep and request writes share one byte-enabled write port.
  assign w_mem_we = ~i_reset & (w_clear | (w_accept & io_bus.req_write & w_in_range));
  assign w_widx   = w_clear ? r_cnt : w_idx;
  assign w_wbe    = w_clear ? {BE_WIDTH{1'b1}} : io_bus.req_be;
  assign w_wdata  = w_clear ? '0 : io_bus.req_wdata;

  // Per-byte write; bytes with a clear enable keep their old contents.
  always_ff @(posedge i_clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < BE_WIDTH; b++)
        if (w_wbe[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  assign w_rsp_in.valid = w_accept;
  assign w_rsp_in.error = w_accept & ~w_in_range;
  assign w_rsp_in.rdata = (w_accept & ~io_bus.req_write & w_in_range) ? r_mem[w_idx] : '0;

  mem_rsp_pipe #(.LATENCY(READ_LATENCY), .rsp_t(rsp_t)) u_rsp_pipe (
    .i_clock (i_clock),
    .i_flush (i_reset),
    .i_rsp   (w_rsp_in),
    .o_rsp   (w_rsp_out)
  );

  assign io_bus.rsp_valid = w_rsp_out.valid;
  assign io_bus.rsp_rdata = w_rsp_out.rdata;
  assign io_bus.rsp_error = w_rsp_out.error;
endmodule

// File: tb/tb_data_mem_bank.sv
// Drives four banks (READ_LATENCY 1..4) with identical traffic and checks
// each against a cycle-stamped reference of expected responses.
module tb_data_mem_bank;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int AIW   = $clog2(DEPTH);
  localparam int NL    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0;
  logic          s_write = 1'b0;
  logic [AW-1:0] s_addr  = '0;
  logic [DW-1:0] s_wdata = '0;
  logic [3:0]    s_be    = '0;

  logic [NL-1:0] rdy, rv, re;
  logic [DW-1:0] rd [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    data_mem_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.req_valid = s_valid;
    assign bus.req_write = s_write;
    assign bus.req_addr  = s_addr;
    assign bus.req_wdata = s_wdata;
    assign bus.req_be    = s_be;
    data_mem_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(g + 1)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus.slave)
    );
    assign rdy[g] = bus.req_ready;
    assign rv[g]  = bus.rsp_valid;
    assign rd[g]  = bus.rsp_rdata;
    assign re[g]  = bus.rsp_error;
  end

  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t          q [NL][$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc = 0, since_rst = 0, n_acc = 0;
  int            n_chk = 0, n_pass = 0;
  int            n_rsp [NL];
  logic [DW-1:0] last_rd [NL];
  logic          last_err [NL];
  logic          last_acc = 1'b0;

  // One clock: update the model at the edge, compare every bank at the negedge.
  task automatic step();
    exp_t x;
    logic in_r;
    logic ev;
    @(posedge clk);
    cyc++;
    last_acc = 1'b0;
    if (rst) begin
      since_rst = 0;
      for (int g = 0; g < NL; g++) q[g].delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      if (s_valid && since_rst >= DEPTH) begin
        last_acc = 1'b1;
        n_acc++;
        in_r = (s_addr < AW'(DEPTH));
        x.e  = !in_r;
        x.d  = '0;
        if (in_r && !s_write) x.d = ref_mem[s_addr[AIW-1:0]];
        if (in_r && s_write)
          for (int b = 0; b < 4; b++)
            if (s_be[b]) ref_mem[s_addr[AIW-1:0]][8*b +: 8] = s_wdata[8*b +: 8];
        for (int g = 0; g < NL; g++) begin
          x.due = cyc + g;
          q[g].push_back(x);
        end
      end
      since_rst++;
    end
    @(negedge clk);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (rdy[g] !== (since_rst >= DEPTH)) $display("FAIL ready L%0d cyc %0d: got %b want %b", g+1, cyc, rdy[g], since_rst >= DEPTH);
      else n_pass++;
      ev = (q[g].size() > 0) && (q[g][0].due == cyc);
      n_chk++;
      if (rv[g] !== ev) $display("FAIL rsp_valid L%0d cyc %0d: got %b want %b", g+1, cyc, rv[g], ev);
      else n_pass++;
      if (ev) begin
        n_chk++;
        if (rd[g] !== q[g][0].d || re[g] !== q[g][0].e)
          $display("FAIL rsp_data L%0d cyc %0d: got %h/%b want %h/%b", g+1, cyc, rd[g], re[g], q[g][0].d, q[g][0].e);
        else n_pass++;
        void'(q[g].pop_front());
      end
      if (rv[g] === 1'b1) begin
        n_rsp[g]++;
        last_rd[g]  = rd[g];
        last_err[g] = re[g];
      end
    end
  endtask

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    s_valid = 1'b1; s_write = w; s_addr = a; s_wdata = d; s_be = be;
    step();
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (rdy[0] !== 1'b1 && t < 2000) begin t++; step(); end
    n_chk++;
    if (t != DEPTH) $display("FAIL %s init_cycles: got %0d want %0d", tag, t, DEPTH);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_write = 1'b0; s_addr = 6; s_be = 4'h0;
    step(); step();
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (rdy[g] !== 1'b0 || rv[g] !== 1'b0 || re[g] !== 1'b0 || rd[g] !== '0)
        $display("FAIL reset_outputs L%0d: got %b%b%b %h want 0000 0", g+1, rdy[g], rv[g], re[g], rd[g]);
      else n_pass++;
      n_rsp[g] = 0;
      last_rd[g] = 'x;
    end
    rst = 1'b0;
    wait_ready("reset");            // read of addr 6 is held through init
    step();
    n_chk++;
    if (!last_acc) $display("FAIL held_req_accept: got 0 want 1");
    else n_pass++;
    s_valid = 1'b0;
    drain(4);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (n_rsp[g] != 1 || last_rd[g] !== 32'h0)
        $display("FAIL reset_read6 L%0d: got n=%0d d=%h want n=1 d=0", g+1, n_rsp[g], last_rd[g]);
      else n_pass++;
    end
  endtask

  task automatic test_byte_mask();
    req(1'b1, 1, 32'hDEADBEEF, 4'hF);
    req(1'b1, 1, 32'h000000AA, 4'h1);
    req(1'b0, 1, 32'h0, 4'h0);
    drain(5);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (last_rd[g] !== 32'hDEADBEAA || last_err[g] !== 1'b0)
        $display("FAIL byte_mask L%0d: got %h/%b want deadbeaa/0", g+1, last_rd[g], last_err[g]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int base [NL];
    for (int g = 0; g < NL; g++) base[g] = n_rsp[g];
    for (int i = 0; i < 8; i++) req(1'b1, i, $urandom, 4'hF);
    for (int i = 0; i < 8; i++) req(1'b0, i, 32'h0, 4'h0);
    drain(5);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (n_rsp[g] - base[g] != 16) $display("FAIL b2b_count L%0d: got %0d want 16", g+1, n_rsp[g] - base[g]);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    req(1'b1, 0, 32'h12345678, 4'hF);
    req(1'b0, 1024, 32'h0, 4'h0);
    drain(5);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (last_rd[g] !== '0 || last_err[g] !== 1'b1) $display("FAIL oor_read L%0d: got %h/%b want 0/1", g+1, last_rd[g], last_err[g]);
      else n_pass++;
    end
    req(1'b1, 32'hFFFFFFFF, 32'hCAFEF00D, 4'hF);
    req(1'b1, 32'h00000400, 32'hBAADF00D, 4'hF);
    drain(5);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (last_rd[g] !== '0 || last_err[g] !== 1'b1) $display("FAIL oor_write L%0d: got %h/%b want 0/1", g+1, last_rd[g], last_err[g]);
      else n_pass++;
    end
    req(1'b0, 0, 32'h0, 4'h0);
    drain(5);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (last_rd[g] !== 32'h12345678 || last_err[g] !== 1'b0) $display("FAIL oor_addr0 L%0d: got %h want 12345678", g+1, last_rd[g]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    int base [NL];
    req(1'b1, 5, 32'h5A5A5A5A, 4'hF);
    drain(5);
    for (int g = 0; g < NL; g++) base[g] = n_rsp[g];
    req(1'b0, 5, 32'h0, 4'h0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (n_rsp[g] - base[g] != (g == 0 ? 1 : 0))
        $display("FAIL flush L%0d: got %0d rsp want %0d", g+1, n_rsp[g] - base[g], g == 0 ? 1 : 0);
      else n_pass++;
    end
    wait_ready("midflight");
    req(1'b0, 5, 32'h0, 4'h0);
    drain(5);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (last_rd[g] !== 32'h0) $display("FAIL reinit_read5 L%0d: got %h want 0", g+1, last_rd[g]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int base [NL];
    int acc0 = n_acc;
    for (int g = 0; g < NL; g++) base[g] = n_rsp[g];
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom % 10) < 7;
      s_write = $urandom % 2;
      s_addr  = ($urandom % 16 == 0) ? AW'($urandom) : AW'($urandom % 32);
      s_wdata = $urandom;
      s_be    = 4'($urandom % 16);
      step();
    end
    s_valid = 1'b0;
    drain(6);
    for (int g = 0; g < NL; g++) begin
      n_chk++;
      if (n_rsp[g] - base[g] != n_acc - acc0)
        $display("FAIL random_count L%0d: got %0d want %0d", g+1, n_rsp[g] - base[g], n_acc - acc0);
      else n_pass++;
      n_chk++;
      if (q[g].size() != 0) $display("FAIL random_pending L%0d: got %0d want 0", g+1, q[g].size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_byte_mask();
    test_back_to_back();
    test_out_of_range();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
